alu_uart_frontend: RTL and testbench

// - Drives the ALU operand/opcode inputs from a byte stream delivered by the UART receiver.
// - Returns the ALU result to the UART transmitter.
// - Collects three bytes in order: A, B, OpCode. Then presents them to the ALU, captures the result and sends it back as one byte.
// - Sits between uart_rx/uart_tx and the ALU; it is the only driver of the ALU inputs.

---
 rtl/alu_uart_frontend_if.sv | 36 +++
 rtl/alu_uart_frontend.sv | 132 +++++++++++++
 tb/tb_alu_uart_frontend.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/alu_uart_frontend_if.sv
// ---------------------------------------------------------------------------
// alu_uart_frontend_if
// Groups every non-clock signal of the UART <-> ALU frontend.
//   UART receiver side : rx_data[7:0], rx_done
//   UART transmitter   : tx_busy, tx_done (to frontend); tx_data[7:0], tx_start
//   ALU side           : alu_result[N-1:0] (to frontend); bus_a, bus_b, op_code
//   Status             : busy
// Modports:
//   master - the frontend itself (drives ALU inputs and the transmitter)
//   slave  - the surrounding UART/ALU environment
// ---------------------------------------------------------------------------
interface alu_uart_frontend_if #(
   parameter int N = 7
) ();
   logic [7:0]   rx_data;
   logic         rx_done;
   logic         tx_busy;
   logic         tx_done;
   logic [N-1:0] alu_result;
   logic [N-1:0] bus_a;
   logic [N-1:0] bus_b;
   logic [5:0]   op_code;
   logic [7:0]   tx_data;
   logic         tx_start;
   logic         busy;

   modport master (
      input  rx_data, rx_done, tx_busy, tx_done, alu_result,
      output bus_a, bus_b, op_code, tx_data, tx_start, busy
   );

   modport slave (
      output rx_data, rx_done, tx_busy, tx_done, alu_result,
      input  bus_a, bus_b, op_code, tx_data, tx_start, busy
   );
endinterface

// File: rtl/alu_uart_frontend.sv
// ---------------------------------------------------------------------------
// alu_uart_frontend
// Collects a three-byte frame (A, B, OpCode) from the UART receiver, drives
// the ALU operand/opcode registers, captures the ALU result one cycle later
// and hands it to the UART transmitter as a single zero-extended byte.
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous, active-low reset
//   bus    - alu_uart_frontend_if.master (UART rx/tx handshake, ALU bus, busy)
// Parameters:
//   N       - ALU data width (1..8)
//   TIMEOUT - idle clocks allowed between bytes of one frame
// ---------------------------------------------------------------------------
module alu_uart_frontend #(
   parameter int N       = 7,
   parameter int TIMEOUT = 50000
) (
   input  logic                  clk,
   input  logic                  reset,
   alu_uart_frontend_if.master   bus
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_GET_A,
      S_GET_B,
      S_GET_OP,
      S_EXEC,
      S_SEND,
      S_WAIT_TX
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  bus_a_q, bus_a_d;
   logic [N-1:0]  bus_b_q, bus_b_d;
   logic [5:0]    op_code_q, op_code_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic          tx_start;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge value of every other flop, independent of statement order.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= S_GET_A;
         cnt_q     <= '0;
         bus_a_q   <= '0;
         bus_b_q   <= '0;
         op_code_q <= '0;
         tx_data_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bus_a_q   <= bus_a_d;
         bus_b_q   <= bus_b_d;
         op_code_q <= op_code_d;
         tx_data_q <= tx_data_d;
      end
   end

   // NOTE: every signal written here gets a default first, so no path through
   // the case leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bus_a_d   = bus_a_q;
      bus_b_d   = bus_b_q;
      op_code_d = op_code_q;
      tx_data_d = tx_data_q;
      tx_start  = 1'b0;

      case (state_q)
         S_GET_A: begin
            if (bus.rx_done) begin
               bus_a_d = bus.rx_data[N-1:0];
               cnt_d   = '0;
               state_d = S_GET_B;
            end
         end
         S_GET_B: begin
            // A byte arriving on the expiry cycle wins over the timeout.
            if (bus.rx_done) begin
               bus_b_d = bus.rx_data[N-1:0];
               cnt_d   = '0;
               state_d = S_GET_OP;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = S_GET_A;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_GET_OP: begin
            if (bus.rx_done) begin
               op_code_d = bus.rx_data[5:0];
               cnt_d     = '0;
               state_d   = S_EXEC;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = S_GET_A;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_EXEC: begin
            // Operands settled during this cycle; capture the ALU result.
            tx_data_d = 8'(bus.alu_result);
            state_d   = S_SEND;
         end
         S_SEND: begin
            if (!bus.tx_busy) begin
               tx_start = 1'b1;
               state_d  = S_WAIT_TX;
            end
         end
         S_WAIT_TX: begin
            if (bus.tx_done) state_d = S_GET_A;
         end
         default: state_d = S_GET_A;
      endcase
   end

   assign bus.bus_a    = bus_a_q;
   assign bus.bus_b    = bus_b_q;
   assign bus.op_code  = op_code_q;
   assign bus.tx_data  = tx_data_q;
   assign bus.tx_start = tx_start;
   assign bus.busy     = (state_q != S_GET_A);

endmodule

// File: tb/tb_alu_uart_frontend.sv
// ---------------------------------------------------------------------------
// tb_alu_uart_frontend
// Directed bench for alu_uart_frontend (N=7, TIMEOUT=20) with a small
// behavioural ALU and a hand-driven transmitter handshake. Inputs are driven
// and outputs sampled 1 time unit after the falling clock edge.
// ---------------------------------------------------------------------------
module tb_alu_uart_frontend;

   localparam int N       = 7;
   localparam int TIMEOUT = 20;

   logic clk;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   alu_uart_frontend_if #(.N(N)) u_if ();

   alu_uart_frontend #(.N(N), .TIMEOUT(TIMEOUT)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if)
   );

   // Behavioural ALU: add, sub, arithmetic shift right by one, and, or.
   always_comb begin
      case (u_if.op_code)
         6'h20:   u_if.alu_result = u_if.bus_a + u_if.bus_b;
         6'h22:   u_if.alu_result = u_if.bus_a - u_if.bus_b;
         6'h03:   u_if.alu_result = $signed(u_if.bus_a) >>> 1;
         6'h24:   u_if.alu_result = u_if.bus_a & u_if.bus_b;
         6'h25:   u_if.alu_result = u_if.bus_a | u_if.bus_b;
         default: u_if.alu_result = '0;
      endcase
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic rx_byte(input logic [7:0] b);
      u_if.rx_data = b;
      u_if.rx_done = 1'b1;
      cyc();
      u_if.rx_done = 1'b0;
   endtask

   // Transmitter handshake from WAIT_TX back to GET_A.
   task automatic tx_handshake();
      u_if.tx_busy = 1'b1;
      repeat (3) cyc();
      check("busy_in_wait_tx", 32'(u_if.busy), 32'd1);
      u_if.tx_busy = 1'b0;
      u_if.tx_done = 1'b1;
      cyc();
      u_if.tx_done = 1'b0;
      check("busy_after_tx_done", 32'(u_if.busy), 32'd0);
   endtask

   // OpCode byte onward: EXEC, SEND (tx_busy low), WAIT_TX, handshake.
   task automatic finish_op(input logic [7:0] op, input logic [7:0] exp);
      rx_byte(op);
      check("op_code", 32'(u_if.op_code), 32'(op[5:0]));
      check("tx_start_exec", 32'(u_if.tx_start), 32'd0);
      check("busy_exec", 32'(u_if.busy), 32'd1);
      cyc();
      check("tx_start_send", 32'(u_if.tx_start), 32'd1);
      check("tx_data", 32'(u_if.tx_data), 32'(exp));
      cyc();
      check("tx_start_one_pulse", 32'(u_if.tx_start), 32'd0);
      tx_handshake();
   endtask

   task automatic run_frame(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] op, input logic [7:0] exp);
      rx_byte(a);
      check("bus_a", 32'(u_if.bus_a), 32'(a[6:0]));
      check("busy_get_b", 32'(u_if.busy), 32'd1);
      rx_byte(b);
      check("bus_b", 32'(u_if.bus_b), 32'(b[6:0]));
      finish_op(op, exp);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_bus_a"},    32'(u_if.bus_a),    32'd0);
      check({tag, "_bus_b"},    32'(u_if.bus_b),    32'd0);
      check({tag, "_op_code"},  32'(u_if.op_code),  32'd0);
      check({tag, "_tx_data"},  32'(u_if.tx_data),  32'd0);
      check({tag, "_tx_start"}, 32'(u_if.tx_start), 32'd0);
      check({tag, "_busy"},     32'(u_if.busy),     32'd0);
   endtask

   initial begin
      int pulses;
      reset        = 1'b0;
      u_if.rx_data = '0;
      u_if.rx_done = 1'b0;
      u_if.tx_busy = 1'b0;
      u_if.tx_done = 1'b0;
      repeat (2) cyc();
      check_reset_state("reset");
      reset = 1'b1;
      cyc();

      // Basic frames.
      run_frame(8'h05, 8'h03, 8'h20, 8'h08);
      run_frame(8'h03, 8'h05, 8'h22, 8'h7E);
      run_frame(8'h40, 8'h00, 8'h03, 8'h60);
      run_frame(8'h40, 8'h00, 8'hC3, 8'h60);

      // Timeout: 20 idle cycles in GET_B abandon the frame.
      rx_byte(8'h11);
      repeat (19) cyc();
      check("timeout_not_yet", 32'(u_if.busy), 32'd1);
      cyc();
      check("timeout_expired", 32'(u_if.busy), 32'd0);
      check("timeout_keeps_a", 32'(u_if.bus_a), 32'h11);
      repeat (5) cyc();
      run_frame(8'h01, 8'h02, 8'h25, 8'h03);

      // A byte on the expiry cycle is accepted.
      rx_byte(8'h11);
      repeat (19) cyc();
      rx_byte(8'h0A);
      check("expiry_byte_accepted", 32'(u_if.bus_b), 32'h0A);
      check("expiry_busy", 32'(u_if.busy), 32'd1);
      finish_op(8'h20, 8'h1B);

      // Transmitter busy for 10 cycles on entry to SEND; early tx_done ignored.
      rx_byte(8'h02);
      rx_byte(8'h04);
      u_if.tx_busy = 1'b1;
      rx_byte(8'h20);
      cyc();
      pulses = 0;
      for (int i = 0; i < 9; i++) begin
         if (u_if.tx_start) pulses++;
         u_if.tx_done = (i == 3);
         cyc();
      end
      u_if.tx_done = 1'b0;
      if (u_if.tx_start) pulses++;
      check("no_start_while_tx_busy", 32'(pulses), 32'd0);
      check("busy_in_send", 32'(u_if.busy), 32'd1);
      u_if.tx_busy = 1'b0;
      #1;
      check("start_after_busy_falls", 32'(u_if.tx_start), 32'd1);
      check("tx_data_busy_case", 32'(u_if.tx_data), 32'h06);
      cyc();
      check("start_single_pulse", 32'(u_if.tx_start), 32'd0);
      rx_byte(8'h55);
      check("dropped_byte_bus_a", 32'(u_if.bus_a), 32'h02);
      tx_handshake();
      check("dropped_byte_not_a", 32'(u_if.bus_a), 32'h02);
      run_frame(8'h07, 8'h01, 8'h22, 8'h06);

      // Reset mid-frame after A and B.
      rx_byte(8'h09);
      rx_byte(8'h08);
      reset = 1'b0;
      cyc();
      reset = 1'b1;
      check_reset_state("mid_reset");
      run_frame(8'h05, 8'h03, 8'h20, 8'h08);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
